uart_rx: RTL and testbench

Bit-level UART receiver: the stage directly upstream of RX_LINE.
- Oversamples the asynchronous serial input and deserialises 8N1 frames (LSB first).
- Presents each byte on rx_data with the level-style rx_done handshake that RX_LINE consumes: high when idle or complete, low while a frame is in progress.

---
 rtl/uart_rx.sv | 141 ++++++++++++++
 tb/tb_uart_rx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver with a level-style rx_done handshake (high = idle/complete).
// Define UART_RX_PARITY_EN to receive 8E1 frames and flag parity errors in frame_error.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [2:0]             state;
  logic [CNT_W-1:0]       baud_cnt;
  logic [2:0]             bit_idx;
  logic [7:0]             shift_q;
  logic                   bit_tc;
  logic                   stop_error;

  // Preset to the idle level so leaving reset never looks like a start bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s   = sync_q[SYNC_STAGES-1];
  assign bit_tc = (baud_cnt == BIT_LAST);

`ifdef UART_RX_PARITY_EN
  logic parity_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else if (state == ST_PARITY && bit_tc) begin
      parity_q <= rx_s;
    end
  end

  assign stop_error = ~rx_s | (parity_q != ^shift_q);
`else
  assign stop_error = ~rx_s;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      baud_cnt    <= '0;
      bit_idx     <= 3'd0;
      shift_q     <= 8'h00;
      rx_data     <= 8'h00;
      rx_done     <= 1'b1;
      frame_error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            baud_cnt <= '0;
            state    <= ST_START;
          end
        end
        ST_START: begin
          // Re-check the line mid start bit to reject glitches.
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            if (!rx_s) begin
              rx_done     <= 1'b0;
              frame_error <= 1'b0;
              bit_idx     <= 3'd0;
              state       <= ST_DATA;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_tc) begin
            baud_cnt <= '0;
            shift_q  <= {rx_s, shift_q[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (bit_tc) begin
            baud_cnt <= '0;
            state    <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_tc) begin
            baud_cnt    <= '0;
            rx_data     <= shift_q;
            rx_done     <= 1'b1;
            frame_error <= stop_error;
            state       <= rx_s ? ST_IDLE : ST_BREAK;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_BREAK: begin
          if (rx_s) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: a frame-level queue model predicts each received byte,
// its error flag and its completion latency; directed cases cover glitch, break and reset.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int SYNC = 2;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif
  localparam int LAT  = SYNC + HALF + (PARITY_EN ? 10 : 9) * CPB;
  localparam int FALL = SYNC + HALF;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_error;

  uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .frame_error (frame_error)
  );

  always #5 clock = ~clock;

  int cycle = 0;
  always @(posedge clock) cycle <= cycle + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    int         start;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   last_start = 0;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clock);
  endtask

  // Called at a falling clock edge; leaves rx at the stop-bit level.
  task automatic send_frame(input logic [7:0] data, input logic stop_ok, input logic parity_ok);
    exp_t e;
    e.data  = data;
    e.ferr  = !stop_ok || (PARITY_EN && !parity_ok);
    e.start = cycle;
    last_start = cycle;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    if (PARITY_EN) drive_bit((^data) ^ !parity_ok);
    drive_bit(stop_ok);
  endtask

  task automatic idle_cycles(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 * CPB; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clock);
    end
    check_output("drain", exp_q.size(), 0);
  endtask

  logic       prev_done = 1'b1;
  logic [7:0] last_data = 8'h00;
  int         dt;

  // Compares every rx_done edge against the model queue.
  always @(negedge clock) begin
    if (!reset) begin
      prev_done = 1'b1;
      last_data = 8'h00;
    end else begin
      if (rx_done && !prev_done) begin
        if (exp_q.size() == 0) begin
          check_output("spurious_frame", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          dt = cycle - mon_e.start;
          check_output("rx_data", rx_data, mon_e.data);
          check_output("frame_error", frame_error, mon_e.ferr);
          check_output("done_latency_ok", (dt >= LAT - 1 && dt <= LAT + 1), 1);
          last_data = mon_e.data;
        end
      end else if (!rx_done && prev_done) begin
        dt = cycle - last_start;
        check_output("hold_data", rx_data, last_data);
        check_output("fall_latency_ok", (dt >= FALL - 1 && dt <= FALL + 2), 1);
      end
      prev_done = rx_done;
    end
  end

  initial begin
    logic       any_low;
    logic [7:0] rnd;
    logic       s_ok, p_ok;

    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    check_output("reset_done", rx_done, 1);
    check_output("reset_data", rx_data, 8'h00);
    check_output("reset_ferr", frame_error, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check_output("pulse_done", rx_done, 1);
    check_output("pulse_data", rx_data, 8'h00);
    check_output("pulse_ferr", frame_error, 0);
    @(negedge clock);
    reset = 1'b1;
    idle_cycles(10);

    send_frame(8'h41, 1'b1, 1'b1);
    idle_cycles(5);
    send_frame(8'h0D, 1'b1, 1'b1);
    idle_cycles(5);

    send_frame(8'h44, 1'b1, 1'b1);
    send_frame(8'h41, 1'b1, 1'b1);
    send_frame(8'h4D, 1'b1, 1'b1);
    idle_cycles(2);
    wait_drain();

    rx = 1'b0;
    repeat (3) @(negedge clock);
    rx = 1'b1;
    any_low = 1'b0;
    for (int i = 0; i < 3 * CPB; i++) begin
      @(negedge clock);
      if (!rx_done) any_low = 1'b1;
    end
    check_output("glitch_done_low", any_low, 0);
    check_output("glitch_data", rx_data, 8'h4D);

    send_frame(8'h55, 1'b0, 1'b1);
    rx = 1'b0;
    repeat (40) @(negedge clock);
    idle_cycles(5);
    send_frame(8'h41, 1'b1, 1'b1);
    idle_cycles(5);

    send_frame(8'h41, 1'b1, 1'b1);
    idle_cycles(3);
    if (PARITY_EN) begin
      send_frame(8'h41, 1'b1, 1'b0);
      idle_cycles(3);
    end
    wait_drain();

    for (int n = 0; n < 24; n++) begin
      rnd  = 8'($urandom);
      s_ok = ($urandom_range(0, 7) != 0);
      p_ok = ($urandom_range(0, 5) != 0);
      send_frame(rnd, s_ok, p_ok);
      idle_cycles(s_ok ? $urandom_range(0, 2) : $urandom_range(2, 4));
    end
    idle_cycles(2);
    wait_drain();

    last_start = cycle;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0]);
    #2;
    reset = 1'b0;
    #1;
    check_output("abort_done", rx_done, 1);
    check_output("abort_data", rx_data, 8'h00);
    check_output("abort_ferr", frame_error, 0);
    rx = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    idle_cycles(5);
    send_frame(8'h3C, 1'b1, 1'b1);
    idle_cycles(5);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
